// File: rtl/ca_step_if.sv
// ca_step_if: control/status bundle between a host and the cellular-automaton step engine
interface ca_step_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic [CNT_W-1:0] gens;
  logic [7:0]       rule;
  logic             wrap;
  logic [WIDTH-1:0] row;
  logic [CNT_W-1:0] gen_count;
  logic             busy;
  logic             done;
  modport master (
    output load, seed, start, gens, rule, wrap,
    input  row, gen_count, busy, done
  );
  modport slave (
    input  load, seed, start, gens, rule, wrap,
    output row, gen_count, busy, done
  );
endinterface

// File: rtl/ca_step_engine.sv
// ca_step_engine: runs a 1-D elementary cellular automaton for a requested number of generations
module ca_step_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic   clk,
  input logic   reset,
  ca_step_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] row_q, row_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, gens_q, gens_d;
  logic [7:0]       rule_q, rule_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH+1:0] ext;
  assign cnt_inc = cnt_q + 1'b1;
  // Row padded with its boundary neighbours so every cell sees a 3-bit window; ~k equals 7-k
  assign ext = {wrap_q & row_q[0], row_q, wrap_q & row_q[WIDTH-1]};
  always_comb begin
    nxt = '0;
    for (int i = 0; i < WIDTH; i++) nxt[i] = rule_q[~ext[i+:3]];
  end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    gens_d  = gens_q;
    rule_d  = rule_q;
    wrap_d  = wrap_q;
    case (state_q)
      IDLE: begin
        if (bus.load) row_d = bus.seed;
        else if (bus.start) begin
          rule_d  = bus.rule;
          wrap_d  = bus.wrap;
          gens_d  = bus.gens;
          cnt_d   = '0;
          state_d = (bus.gens == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        row_d   = nxt;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == gens_q) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      gens_q  <= '0;
      rule_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      gens_q  <= gens_d;
      rule_q  <= rule_d;
      wrap_q  <= wrap_d;
    end
  end
  assign bus.row       = row_q;
  assign bus.gen_count = cnt_q;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = state_q == DONE;
endmodule

// File: doc/ca_step_engine.md
CA_STEP_ENGINE -- requirements
Module: ca_step_engine

Interface
REQ-001 Parameter: WIDTH, default 16, number of cells in the automaton row (legal range 3..64).
REQ-002 Parameter: CNT_W, default 8, width of the generation-count request and counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: load  input  1  in IDLE, copy seed into the cell row.
REQ-006 Port: seed  input  WIDTH  initial row value; bit i is cell i.
REQ-007 Port: start  input  1  in IDLE, begin a run of gens generations.
REQ-008 Port: gens  input  CNT_W  number of generations to compute; sampled on accepted start.
REQ-009 Port: rule  input  8  Wolfram rule code; sampled on accepted start.
REQ-010 Port: wrap  input  1  boundary mode (1 = ring, 0 = zero-padded); sampled on accepted start.
REQ-011 Port: row  output  WIDTH  current cell row (registered).
REQ-012 Port: gen_count  output  CNT_W  generations completed in current/last run.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: done  output  1  one-cycle pulse on run completion.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-016 Neighborhood index k = {cell[i+1], cell[i], cell[i-1]} (3 bits, left = higher index); new cell[i] SHALL be rule[7-k], i.e. rule MSB is output for 000, LSB for 111.
REQ-017 wrap=1: cell[WIDTH] reads cell[0], cell[-1] reads cell[WIDTH-1]; wrap=0: both read 0.
REQ-018 All cells SHALL update simultaneously from the previous row; no cell sees a partially updated row.
REQ-019 IDLE, load=1: row <= seed on that edge; start in the same cycle SHALL be ignored (load priority).
REQ-020 IDLE, start=1, load=0: latch rule, wrap, gens; gen_count <= 0; if gens=0 go to DONE, else go to RUN.
REQ-021 RUN: each cycle row <= next generation and gen_count <= gen_count+1; when gen_count+1 = latched gens, go to DONE on that edge.
REQ-022 Latency: start accepted at edge t; N generations complete at edge t+N; done=1 during cycle after edge t+N; busy=1 for exactly N cycles.
REQ-023 DONE: done=1 for exactly one cycle, busy=0, row and gen_count held; next state IDLE unconditionally.
REQ-024 load and start SHALL be ignored in RUN and DONE; changes to rule, wrap, gens, seed during RUN SHALL have no effect.
REQ-025 row and gen_count SHALL hold their values in IDLE except as changed by load or start.
REQ-026 gen_count SHALL not wrap; max run is 2^CNT_W-1 generations.

Reset
REQ-027 reset=1 at any edge SHALL force state IDLE, row=0, gen_count=0, busy=0, done=0, latched rule=0, wrap=0, gens=0, overriding all other inputs.
REQ-028 Reset asserted mid-RUN SHALL abort the run with no done pulse; first legal start is the cycle after reset deasserts.

Verification
REQ-029 WIDTH=8, load seed=8'h00, start rule=8'h96 wrap=0 gens=2 -> row 8'hFF after gen 1, 8'h81 after gen 2; gen_count=2; done pulse one cycle after edge t+2.
REQ-030 WIDTH=8, seed=8'h01, rule=8'h0F (copy left neighbor), wrap=1, gens=3 -> rows 8'h80, 8'h40, 8'h20; busy high exactly 3 cycles.
REQ-031 Same as REQ-030 with wrap=0, gens=1 -> row 8'h00 (bit shifted out, zero injected at cell 7).
REQ-032 rule=8'h33 (identity), any seed, gens=5 -> row unchanged, gen_count=5; gens=0 -> no RUN cycles, done in cycle after start, busy never high.
REQ-033 load and start asserted together in IDLE -> row=seed, FSM stays IDLE, no busy/done; start during RUN -> ignored, run length unchanged.
REQ-034 reset asserted in 2nd RUN cycle of a gens=10 run -> next cycle row=0, gen_count=0, busy=0, no done pulse; subsequent load/start run completes normally.
